// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the pipeline memory stage.
//   MEM_* : funct3 encodings of the load/store access size.
//   state_t : data-memory access FSM state.
//   is_misaligned() : size/offset alignment check.
package cpu_pkg;

  localparam logic [2:0] MEM_B  = 3'b000;
  localparam logic [2:0] MEM_H  = 3'b001;
  localparam logic [2:0] MEM_W  = 3'b010;
  localparam logic [2:0] MEM_BU = 3'b100;
  localparam logic [2:0] MEM_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  // Halfwords need an even address, words a multiple of four; bytes never fault.
  function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] off);
    logic r;
    r = 1'b0;
    if (op == MEM_H || op == MEM_HU) r = off[0];
    else if (op == MEM_W)            r = (off != 2'b00);
    return r;
  endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// mem_access_stage_if: data-memory request/response bus.
//   req/we/addr/be/wdata : request, driven by the stage (master)
//   gnt                  : memory accepts the request this cycle
//   rvalid/rdata         : load response, one per granted load
// Handshake: a request is transferred on a cycle where req=1 and gnt=1.
// Once req rises it stays high with addr/be/wdata/we unchanged until gnt.
// A granted load is completed by exactly one rvalid cycle; no new request
// is issued until that response arrives, so at most one access is open.
interface mem_access_stage_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, we, addr, be, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, be, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/mem_access_stage_load_align.sv
// load_align: selects the addressed byte/halfword of a load data word and
// extends it to 32 bits.
//   rdata_i    : raw memory word
//   byte_off_i : address bits [1:0]
//   mem_op_i   : funct3 access size/sign
//   data_o     : extended load result
module load_align
  import cpu_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  byte_off_i,
  input  logic [2:0]  mem_op_i,
  output logic [31:0] data_o
);

  logic [31:0] shifted;

  // Bring the addressed lane down to bit 0; a word access has offset 0.
  assign shifted = rdata_i >> {byte_off_i, 3'b000};

  always_comb begin
    data_o = shifted;
    case (mem_op_i)
      MEM_B:   data_o = {{24{shifted[7]}}, shifted[7:0]};
      MEM_H:   data_o = {{16{shifted[15]}}, shifted[15:0]};
      MEM_BU:  data_o = {24'd0, shifted[7:0]};
      MEM_HU:  data_o = {16'd0, shifted[15:0]};
      default: data_o = shifted;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM stage of the 5-stage pipeline.
//   clk, rst_n      : clock, asynchronous active-low reset
//   EX_*            : EX/MEM register outputs (access type, address, data, WB info)
//   dmem            : data-memory bus (master side)
//   MEM_stall_o     : hold PC, IF/ID, ID/EX, EX/MEM while an access is open
//   MEM_misalign_o  : registered one-cycle misaligned-access flag
//   MEM_fwd_data_o  : EX ALU result for forwarding (combinational)
//   MEM_*_o         : MEM/WB pipeline register
//   state_o         : access FSM state (debug)
module mem_access_stage
  import cpu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  EX_RD_mem_i,
  input  logic                  EX_WR_mem_i,
  input  logic [3:0]            EX_mem_op_i,
  input  logic [DATA_WIDTH-1:0] EX_alu_result_i,
  input  logic [DATA_WIDTH-1:0] EX_rs2_data_i,
  input  logic [4:0]            EX_rd_add_i,
  input  logic                  EX_regwrite_i,
  input  logic [1:0]            EX_sel_to_reg_i,
  input  logic [DATA_WIDTH-1:0] EX_pc_i,
  mem_access_stage_if.master    dmem,
  output logic                  MEM_stall_o,
  output logic                  MEM_misalign_o,
  output logic [DATA_WIDTH-1:0] MEM_fwd_data_o,
  output logic [4:0]            MEM_rd_add_o,
  output logic                  MEM_regwrite_o,
  output logic [1:0]            MEM_sel_to_reg_o,
  output logic [DATA_WIDTH-1:0] MEM_pc_o,
  output logic [DATA_WIDTH-1:0] MEM_alu_result_o,
  output logic [DATA_WIDTH-1:0] MEM_load_data_o,
  output state_t                state_o
);

  state_t      state;
  logic [2:0]  op;
  logic [1:0]  off;
  logic        acc, misalign, aligned_acc, is_store;
  logic        req_core, load_done;
  logic [31:0] load_ext;
  logic        unused_op_bit;

  assign op            = EX_mem_op_i[2:0];
  assign unused_op_bit = EX_mem_op_i[3];
  assign off           = EX_alu_result_i[1:0];
  assign acc           = EX_RD_mem_i | EX_WR_mem_i;
  assign misalign      = acc & is_misaligned(op, off);
  assign aligned_acc   = acc & ~misalign;
  assign is_store      = EX_WR_mem_i;
  assign req_core      = aligned_acc & (state != ST_WAIT);
  assign load_done     = (state == ST_WAIT) & dmem.rvalid;

  // Request and stall are combinational; gating with rst_n keeps both low
  // while reset is held even though the upstream access may still be present.
  assign dmem.req    = rst_n & req_core;
  assign dmem.we     = is_store;
  assign dmem.addr   = {EX_alu_result_i[31:2], 2'b00};
  assign MEM_stall_o = rst_n & aligned_acc
                     & ~((state != ST_WAIT) & is_store & dmem.gnt)
                     & ~load_done;

  assign MEM_fwd_data_o = EX_alu_result_i;
  assign state_o        = state;

  // Store lanes: the inverse of the load extraction, replicating the data
  // so the enabled lane always carries the right bytes.
  always_comb begin
    dmem.be    = 4'b1111;
    dmem.wdata = EX_rs2_data_i;
    case (op)
      MEM_B: begin
        dmem.be    = 4'b0001 << off;
        dmem.wdata = {4{EX_rs2_data_i[7:0]}};
      end
      MEM_H: begin
        dmem.be    = 4'b0011 << off;
        dmem.wdata = {2{EX_rs2_data_i[15:0]}};
      end
      default: begin
        dmem.be    = 4'b1111;
        dmem.wdata = EX_rs2_data_i;
      end
    endcase
  end

  load_align u_load_align (
    .rdata_i    (dmem.rdata),
    .byte_off_i (off),
    .mem_op_i   (op),
    .data_o     (load_ext)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= ST_IDLE;
      MEM_misalign_o   <= 1'b0;
      MEM_rd_add_o     <= '0;
      MEM_regwrite_o   <= 1'b0;
      MEM_sel_to_reg_o <= '0;
      MEM_pc_o         <= '0;
      MEM_alu_result_o <= '0;
      MEM_load_data_o  <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_REQ: begin
          if (req_core) begin
            if (dmem.gnt) state <= is_store ? ST_IDLE : ST_WAIT;
            else          state <= ST_REQ;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_WAIT: if (dmem.rvalid) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase

      MEM_misalign_o <= misalign;

      if (!MEM_stall_o) begin
        MEM_rd_add_o     <= EX_rd_add_i;
        MEM_regwrite_o   <= EX_regwrite_i & ~misalign;
        MEM_sel_to_reg_o <= EX_sel_to_reg_i;
        MEM_pc_o         <= EX_pc_i;
        MEM_alu_result_o <= EX_alu_result_i;
        MEM_load_data_o  <= load_done ? load_ext : '0;
      end else begin
        // Bubble: nothing retires while the access is open.
        MEM_rd_add_o   <= '0;
        MEM_regwrite_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        EX_RD_mem, EX_WR_mem;
  logic [3:0]  EX_mem_op;
  logic [31:0] EX_alu_result, EX_rs2_data, EX_pc;
  logic [4:0]  EX_rd_add;
  logic        EX_regwrite;
  logic [1:0]  EX_sel_to_reg;
  logic        MEM_stall, MEM_misalign, MEM_regwrite;
  logic [31:0] MEM_fwd_data, MEM_pc, MEM_alu_result, MEM_load_data;
  logic [4:0]  MEM_rd_add;
  logic [1:0]  MEM_sel_to_reg;
  state_t      state_dbg;

  int total = 0;
  int bad   = 0;

  mem_access_stage_if dmem ();

  always #5 clk = ~clk;

  mem_access_stage #(.DATA_WIDTH(32)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .EX_RD_mem_i      (EX_RD_mem),
    .EX_WR_mem_i      (EX_WR_mem),
    .EX_mem_op_i      (EX_mem_op),
    .EX_alu_result_i  (EX_alu_result),
    .EX_rs2_data_i    (EX_rs2_data),
    .EX_rd_add_i      (EX_rd_add),
    .EX_regwrite_i    (EX_regwrite),
    .EX_sel_to_reg_i  (EX_sel_to_reg),
    .EX_pc_i          (EX_pc),
    .dmem             (dmem),
    .MEM_stall_o      (MEM_stall),
    .MEM_misalign_o   (MEM_misalign),
    .MEM_fwd_data_o   (MEM_fwd_data),
    .MEM_rd_add_o     (MEM_rd_add),
    .MEM_regwrite_o   (MEM_regwrite),
    .MEM_sel_to_reg_o (MEM_sel_to_reg),
    .MEM_pc_o         (MEM_pc),
    .MEM_alu_result_o (MEM_alu_result),
    .MEM_load_data_o  (MEM_load_data),
    .state_o          (state_dbg)
  );

  // ---------------- driver tasks ----------------
  task automatic set_ex(input logic rd, input logic wr, input logic [2:0] op,
                        input logic [31:0] addr, input logic [31:0] rs2,
                        input logic [4:0] rdadd, input logic rw);
    EX_RD_mem     = rd;
    EX_WR_mem     = wr;
    EX_mem_op     = {1'b0, op};
    EX_alu_result = addr;
    EX_rs2_data   = rs2;
    EX_rd_add     = rdadd;
    EX_regwrite   = rw;
    EX_sel_to_reg = 2'b01;
    EX_pc         = 32'h0000_1000 + addr;
  endtask

  task automatic clear_ex();
    set_ex(1'b0, 1'b0, MEM_W, 32'h0, 32'h0, 5'd0, 1'b0);
    EX_pc = 32'h0;
    EX_sel_to_reg = 2'b00;
  endtask

  task automatic mem_idle();
    dmem.gnt    = 1'b0;
    dmem.rvalid = 1'b0;
    dmem.rdata  = 32'h0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    clear_ex();
    mem_idle();
    @(negedge clk);
    total++; if (dmem.req !== 1'b0) begin bad++; $display("FAIL rst_req got=%h exp=0", dmem.req); end
    total++; if (MEM_stall !== 1'b0) begin bad++; $display("FAIL rst_stall got=%h exp=0", MEM_stall); end
    total++; if (MEM_regwrite !== 1'b0) begin bad++; $display("FAIL rst_regwrite got=%h exp=0", MEM_regwrite); end
    total++; if (MEM_misalign !== 1'b0) begin bad++; $display("FAIL rst_misalign got=%h exp=0", MEM_misalign); end
    total++; if (MEM_load_data !== 32'h0) begin bad++; $display("FAIL rst_load_data got=%h exp=0", MEM_load_data); end
    total++; if (state_dbg !== ST_IDLE) begin bad++; $display("FAIL rst_state got=%0d exp=%0d", state_dbg, ST_IDLE); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_lw();
    @(negedge clk);
    set_ex(1'b1, 1'b0, MEM_W, 32'h100, 32'h0, 5'd5, 1'b1);
    dmem.gnt = 1'b1;
    #1;
    total++; if (dmem.req !== 1'b1) begin bad++; $display("FAIL lw_req got=%h exp=1", dmem.req); end
    total++; if (dmem.we !== 1'b0) begin bad++; $display("FAIL lw_we got=%h exp=0", dmem.we); end
    total++; if (dmem.addr !== 32'h100) begin bad++; $display("FAIL lw_addr got=%h exp=100", dmem.addr); end
    total++; if (MEM_stall !== 1'b1) begin bad++; $display("FAIL lw_stall_c0 got=%h exp=1", MEM_stall); end
    @(negedge clk);
    dmem.gnt = 1'b0;
    #1;
    total++; if (state_dbg !== ST_WAIT) begin bad++; $display("FAIL lw_state_wait got=%0d exp=%0d", state_dbg, ST_WAIT); end
    total++; if (dmem.req !== 1'b0) begin bad++; $display("FAIL lw_req_wait got=%h exp=0", dmem.req); end
    total++; if (MEM_stall !== 1'b1) begin bad++; $display("FAIL lw_stall_c1 got=%h exp=1", MEM_stall); end
    total++; if (MEM_regwrite !== 1'b0) begin bad++; $display("FAIL lw_bubble got=%h exp=0", MEM_regwrite); end
    @(negedge clk);
    dmem.rvalid = 1'b1;
    dmem.rdata  = 32'hDEADBEEF;
    #1;
    total++; if (MEM_stall !== 1'b0) begin bad++; $display("FAIL lw_stall_c2 got=%h exp=0", MEM_stall); end
    @(negedge clk);
    total++; if (MEM_load_data !== 32'hDEADBEEF) begin bad++; $display("FAIL lw_data got=%h exp=deadbeef", MEM_load_data); end
    total++; if (MEM_regwrite !== 1'b1) begin bad++; $display("FAIL lw_regwrite got=%h exp=1", MEM_regwrite); end
    total++; if (MEM_rd_add !== 5'd5) begin bad++; $display("FAIL lw_rd got=%h exp=5", MEM_rd_add); end
    total++; if (state_dbg !== ST_IDLE) begin bad++; $display("FAIL lw_state_idle got=%0d exp=%0d", state_dbg, ST_IDLE); end
    mem_idle();
    clear_ex();
  endtask

  task automatic test_load_ext();
    logic [2:0]  ops   [5];
    logic [31:0] addrs [5];
    logic [31:0] rdats [5];
    logic [31:0] exps  [5];
    ops[0] = MEM_B;  addrs[0] = 32'h103; rdats[0] = 32'h80000000; exps[0] = 32'hFFFFFF80;
    ops[1] = MEM_BU; addrs[1] = 32'h103; rdats[1] = 32'h80000000; exps[1] = 32'h00000080;
    ops[2] = MEM_HU; addrs[2] = 32'h102; rdats[2] = 32'hBEEF0000; exps[2] = 32'h0000BEEF;
    ops[3] = MEM_H;  addrs[3] = 32'h100; rdats[3] = 32'h00008001; exps[3] = 32'hFFFF8001;
    ops[4] = MEM_H;  addrs[4] = 32'h102; rdats[4] = 32'h7FFF0000; exps[4] = 32'h00007FFF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      set_ex(1'b1, 1'b0, ops[i], addrs[i], 32'h0, 5'd7, 1'b1);
      dmem.gnt = 1'b1;
      @(negedge clk);
      dmem.gnt    = 1'b0;
      dmem.rvalid = 1'b1;
      dmem.rdata  = rdats[i];
      @(negedge clk);
      total++;
      if (MEM_load_data !== exps[i]) begin
        bad++;
        $display("FAIL load_ext[%0d] got=%h exp=%h", i, MEM_load_data, exps[i]);
      end
      mem_idle();
      clear_ex();
    end
  endtask

  task automatic test_store();
    @(negedge clk);
    set_ex(1'b0, 1'b1, MEM_H, 32'h102, 32'h00001234, 5'd0, 1'b0);
    dmem.gnt = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      total++; if (dmem.req !== 1'b1) begin bad++; $display("FAIL sh_req[%0d] got=%h exp=1", c, dmem.req); end
      total++; if (dmem.we !== 1'b1) begin bad++; $display("FAIL sh_we[%0d] got=%h exp=1", c, dmem.we); end
      total++; if (dmem.addr !== 32'h100) begin bad++; $display("FAIL sh_addr[%0d] got=%h exp=100", c, dmem.addr); end
      total++; if (dmem.be !== 4'b1100) begin bad++; $display("FAIL sh_be[%0d] got=%b exp=1100", c, dmem.be); end
      total++; if (dmem.wdata !== 32'h12341234) begin bad++; $display("FAIL sh_wdata[%0d] got=%h exp=12341234", c, dmem.wdata); end
      total++; if (MEM_stall !== 1'b1) begin bad++; $display("FAIL sh_stall[%0d] got=%h exp=1", c, MEM_stall); end
      @(negedge clk);
    end
    dmem.gnt = 1'b1;
    #1;
    total++; if (state_dbg !== ST_REQ) begin bad++; $display("FAIL sh_state_req got=%0d exp=%0d", state_dbg, ST_REQ); end
    total++; if (MEM_stall !== 1'b0) begin bad++; $display("FAIL sh_stall_gnt got=%h exp=0", MEM_stall); end
    @(negedge clk);
    dmem.gnt = 1'b0;
    clear_ex();
    #1;
    total++; if (state_dbg !== ST_IDLE) begin bad++; $display("FAIL sh_state_idle got=%0d exp=%0d", state_dbg, ST_IDLE); end
    // SB with same-cycle grant: single cycle, no stall.
    @(negedge clk);
    set_ex(1'b0, 1'b1, MEM_B, 32'h101, 32'h000000AB, 5'd0, 1'b0);
    dmem.gnt = 1'b1;
    #1;
    total++; if (dmem.be !== 4'b0010) begin bad++; $display("FAIL sb_be got=%b exp=0010", dmem.be); end
    total++; if (dmem.wdata !== 32'hABABABAB) begin bad++; $display("FAIL sb_wdata got=%h exp=abababab", dmem.wdata); end
    total++; if (MEM_stall !== 1'b0) begin bad++; $display("FAIL sb_stall got=%h exp=0", MEM_stall); end
    @(negedge clk);
    dmem.gnt = 1'b0;
    clear_ex();
    #1;
    total++; if (state_dbg !== ST_IDLE) begin bad++; $display("FAIL sb_state got=%0d exp=%0d", state_dbg, ST_IDLE); end
  endtask

  task automatic test_misalign();
    @(negedge clk);
    set_ex(1'b1, 1'b0, MEM_W, 32'h102, 32'h0, 5'd9, 1'b1);
    #1;
    total++; if (dmem.req !== 1'b0) begin bad++; $display("FAIL mis_req got=%h exp=0", dmem.req); end
    total++; if (MEM_stall !== 1'b0) begin bad++; $display("FAIL mis_stall got=%h exp=0", MEM_stall); end
    @(negedge clk);
    total++; if (MEM_misalign !== 1'b1) begin bad++; $display("FAIL mis_flag got=%h exp=1", MEM_misalign); end
    total++; if (MEM_regwrite !== 1'b0) begin bad++; $display("FAIL mis_regwrite got=%h exp=0", MEM_regwrite); end
    clear_ex();
    @(negedge clk);
    total++; if (MEM_misalign !== 1'b0) begin bad++; $display("FAIL mis_pulse got=%h exp=0", MEM_misalign); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    set_ex(1'b1, 1'b0, MEM_W, 32'h200, 32'h0, 5'd4, 1'b1);
    dmem.gnt = 1'b1;
    @(negedge clk);
    dmem.gnt = 1'b0;
    #1;
    total++; if (state_dbg !== ST_WAIT) begin bad++; $display("FAIL rm_wait got=%0d exp=%0d", state_dbg, ST_WAIT); end
    rst_n = 1'b0;
    #1;
    total++; if (state_dbg !== ST_IDLE) begin bad++; $display("FAIL rm_state got=%0d exp=%0d", state_dbg, ST_IDLE); end
    total++; if (MEM_stall !== 1'b0) begin bad++; $display("FAIL rm_stall got=%h exp=0", MEM_stall); end
    total++; if (dmem.req !== 1'b0) begin bad++; $display("FAIL rm_req got=%h exp=0", dmem.req); end
    @(negedge clk);
    clear_ex();
    rst_n = 1'b1;
    @(negedge clk);
    dmem.rvalid = 1'b1;
    dmem.rdata  = 32'h12345678;
    @(negedge clk);
    mem_idle();
    total++; if (MEM_load_data !== 32'h0) begin bad++; $display("FAIL rm_data got=%h exp=0", MEM_load_data); end
    total++; if (MEM_regwrite !== 1'b0) begin bad++; $display("FAIL rm_regwrite got=%h exp=0", MEM_regwrite); end
    total++; if (state_dbg !== ST_IDLE) begin bad++; $display("FAIL rm_idle got=%0d exp=%0d", state_dbg, ST_IDLE); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    set_ex(1'b0, 1'b0, MEM_W, 32'h11, 32'h0, 5'd1, 1'b1);
    #1;
    total++; if (MEM_fwd_data !== 32'h11) begin bad++; $display("FAIL b2b_fwd0 got=%h exp=11", MEM_fwd_data); end
    total++; if (MEM_stall !== 1'b0) begin bad++; $display("FAIL b2b_stall0 got=%h exp=0", MEM_stall); end
    @(negedge clk);
    total++; if (MEM_rd_add !== 5'd1) begin bad++; $display("FAIL b2b_rd0 got=%h exp=1", MEM_rd_add); end
    total++; if (MEM_alu_result !== 32'h11) begin bad++; $display("FAIL b2b_alu0 got=%h exp=11", MEM_alu_result); end
    set_ex(1'b1, 1'b0, MEM_W, 32'h300, 32'h0, 5'd2, 1'b1);
    dmem.gnt = 1'b1;
    #1;
    total++; if (MEM_fwd_data !== 32'h300) begin bad++; $display("FAIL b2b_fwd1 got=%h exp=300", MEM_fwd_data); end
    total++; if (MEM_stall !== 1'b1) begin bad++; $display("FAIL b2b_stall1 got=%h exp=1", MEM_stall); end
    @(negedge clk);
    dmem.gnt    = 1'b0;
    dmem.rvalid = 1'b1;
    dmem.rdata  = 32'hCAFEF00D;
    #1;
    total++; if (MEM_regwrite !== 1'b0) begin bad++; $display("FAIL b2b_bubble got=%h exp=0", MEM_regwrite); end
    total++; if (MEM_stall !== 1'b0) begin bad++; $display("FAIL b2b_stall2 got=%h exp=0", MEM_stall); end
    @(negedge clk);
    total++; if (MEM_rd_add !== 5'd2) begin bad++; $display("FAIL b2b_rd1 got=%h exp=2", MEM_rd_add); end
    total++; if (MEM_load_data !== 32'hCAFEF00D) begin bad++; $display("FAIL b2b_ld got=%h exp=cafef00d", MEM_load_data); end
    mem_idle();
    set_ex(1'b0, 1'b0, MEM_W, 32'h33, 32'h0, 5'd3, 1'b1);
    #1;
    total++; if (MEM_fwd_data !== 32'h33) begin bad++; $display("FAIL b2b_fwd2 got=%h exp=33", MEM_fwd_data); end
    @(negedge clk);
    total++; if (MEM_rd_add !== 5'd3) begin bad++; $display("FAIL b2b_rd2 got=%h exp=3", MEM_rd_add); end
    total++; if (MEM_alu_result !== 32'h33) begin bad++; $display("FAIL b2b_alu2 got=%h exp=33", MEM_alu_result); end
    total++; if (MEM_regwrite !== 1'b1) begin bad++; $display("FAIL b2b_rw2 got=%h exp=1", MEM_regwrite); end
    clear_ex();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired bad=%0d", bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_lw();
    test_load_ext();
    test_store();
    test_misalign();
    test_reset_mid();
    test_back_to_back();
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
